// File: rtl/pkt_out_buf.sv
// Reads stored packets out of the no-cut packet RAM, forwards metadata and data words, and owns the buffer-ID free pool.
// Optional saturating error counters are built when PKT_OUT_BUF_ERRCNT_EN is defined.
module pkt_out_buf #(
    parameter int         RAM_RD_LAT   = 2,
    parameter logic [7:0] USEDW_THRESH = 8'd120,
    parameter int         MAX_WORDS    = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [339:0] pkt_metadata_nocut,
    input  logic         pkt_metadata_nocut_valid,
    output logic [10:0]  nocut_pkt_ram_rd_addr,
    output logic         nocut_pkt_ram_rd,
    input  logic [138:0] nocut_pkt_ram_data_q,
    output logic         buf_addr_wr,
    output logic [3:0]   buf_addr,
    output logic [339:0] pkt_metadata_out,
    output logic         pkt_metadata_out_valid,
    output logic [138:0] pkt_out_data,
    output logic         pkt_out_data_valid,
    input  logic [7:0]   pkt_out_data_usedw
`ifdef PKT_OUT_BUF_ERRCNT_EN
    ,
    output logic [15:0]  err_missing_tail_cnt,
    output logic [15:0]  err_meta_drop_cnt
`endif
);

    // state | meaning: INIT_S seed IDs 0..15 | IDLE_S wait for queued meta | META_S pop, emit meta | WAIT_S consumer room
    // READ_S issue reads, forward words | DRAIN_S discard over-reads | FREE_S return the ID upstream
    typedef enum logic [2:0] {INIT_S, IDLE_S, META_S, WAIT_S, READ_S, DRAIN_S, FREE_S} state_t;

    localparam logic [2:0] TAIL = 3'b110;

    state_t         state_q, state_d;
    logic [3:0]     init_cnt_q, init_cnt_d;
    logic [3:0]     id_q, id_d;
    logic [7:0]     offset_q, offset_d;
    logic [7:0]     ret_cnt_q, ret_cnt_d;
    logic [1:0]     drain_cnt_q, drain_cnt_d;
    logic [RAM_RD_LAT-1:0] vld_sr_q;

    logic           rd_q, rd_d;
    logic [10:0]    rd_addr_q, rd_addr_d;
    logic           buf_wr_q, buf_wr_d;
    logic [3:0]     buf_addr_q, buf_addr_d;
    logic [339:0]   meta_q, meta_d;
    logic           meta_vld_q, meta_vld_d;
    logic [138:0]   data_q, data_d;
    logic           data_vld_q, data_vld_d;

    logic [339:0]   q_mem_q [16];
    logic [3:0]     q_wr_ptr_q, q_rd_ptr_q;
    logic [4:0]     q_cnt_q;
    logic           q_full, q_empty, q_push, q_pop;
    logic [339:0]   q_head;

    logic           ret_vld, ret_tail, miss_tail;

    assign q_full  = (q_cnt_q == 5'd16);
    assign q_empty = (q_cnt_q == 5'd0);
    assign q_push  = pkt_metadata_nocut_valid && !q_full;
    assign q_head  = q_mem_q[q_rd_ptr_q];

    assign ret_vld   = vld_sr_q[RAM_RD_LAT-1];
    assign ret_tail  = (nocut_pkt_ram_data_q[138:136] == TAIL);
    assign miss_tail = (state_q == READ_S) && ret_vld && !ret_tail &&
                       (ret_cnt_q == 8'(MAX_WORDS - 1));

    always_ff @(posedge clk) begin
        if (q_push) q_mem_q[q_wr_ptr_q] <= pkt_metadata_nocut;
    end

    always_comb begin
        logic go_drain;
        go_drain    = 1'b0;
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        id_d        = id_q;
        offset_d    = offset_q;
        ret_cnt_d   = ret_cnt_q;
        drain_cnt_d = drain_cnt_q;
        q_pop       = 1'b0;
        rd_d        = 1'b0;
        rd_addr_d   = rd_addr_q;
        buf_wr_d    = 1'b0;
        buf_addr_d  = buf_addr_q;
        meta_d      = meta_q;
        meta_vld_d  = 1'b0;
        data_d      = data_q;
        data_vld_d  = 1'b0;
        case (state_q)
            INIT_S: begin
                buf_wr_d   = 1'b1;
                buf_addr_d = init_cnt_q;
                init_cnt_d = init_cnt_q + 4'd1;
                if (init_cnt_q == 4'd15) state_d = IDLE_S;
            end
            IDLE_S: if (!q_empty) state_d = META_S;
            META_S: begin
                q_pop      = 1'b1;
                id_d       = q_head[339:336];
                meta_d     = {4'b0, q_head[335:0]};
                meta_vld_d = 1'b1;
                offset_d   = 8'd0;
                ret_cnt_d  = 8'd0;
                state_d    = WAIT_S;
            end
            WAIT_S: begin
                if (pkt_out_data_usedw <= USEDW_THRESH) begin
                    rd_d      = 1'b1;
                    rd_addr_d = {id_q, offset_q[6:0]};
                    offset_d  = offset_q + 8'd1;
                    state_d   = READ_S;
                end
            end
            READ_S: begin
                if (ret_vld) begin
                    data_vld_d = 1'b1;
                    data_d     = nocut_pkt_ram_data_q;
                    ret_cnt_d  = ret_cnt_q + 8'd1;
                    // a packet that never shows a tail is closed off on its last word
                    if (miss_tail) data_d[138:136] = TAIL;
                    go_drain = ret_tail || miss_tail;
                end
                if (go_drain) begin
                    state_d     = DRAIN_S;
                    drain_cnt_d = 2'(RAM_RD_LAT - 1);
                end else if (offset_q < 8'(MAX_WORDS)) begin
                    rd_d      = 1'b1;
                    rd_addr_d = {id_q, offset_q[6:0]};
                    offset_d  = offset_q + 8'd1;
                end
            end
            DRAIN_S: begin
                if (drain_cnt_q == 2'd0) state_d = FREE_S;
                else                     drain_cnt_d = drain_cnt_q - 2'd1;
            end
            FREE_S: begin
                buf_wr_d   = 1'b1;
                buf_addr_d = id_q;
                state_d    = IDLE_S;
            end
            default: state_d = INIT_S;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= INIT_S;
            init_cnt_q  <= 4'd0;
            id_q        <= 4'd0;
            offset_q    <= 8'd0;
            ret_cnt_q   <= 8'd0;
            drain_cnt_q <= 2'd0;
            vld_sr_q    <= '0;
            q_wr_ptr_q  <= 4'd0;
            q_rd_ptr_q  <= 4'd0;
            q_cnt_q     <= 5'd0;
            rd_q        <= 1'b0;
            rd_addr_q   <= 11'd0;
            buf_wr_q    <= 1'b0;
            buf_addr_q  <= 4'd0;
            meta_q      <= '0;
            meta_vld_q  <= 1'b0;
            data_q      <= '0;
            data_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            id_q        <= id_d;
            offset_q    <= offset_d;
            ret_cnt_q   <= ret_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            vld_sr_q[0] <= rd_q;
            for (int i = 1; i < RAM_RD_LAT; i++) vld_sr_q[i] <= vld_sr_q[i-1];
            if (q_push) q_wr_ptr_q <= q_wr_ptr_q + 4'd1;
            if (q_pop)  q_rd_ptr_q <= q_rd_ptr_q + 4'd1;
            q_cnt_q     <= q_cnt_q + {4'd0, q_push} - {4'd0, q_pop};
            rd_q        <= rd_d;
            rd_addr_q   <= rd_addr_d;
            buf_wr_q    <= buf_wr_d;
            buf_addr_q  <= buf_addr_d;
            meta_q      <= meta_d;
            meta_vld_q  <= meta_vld_d;
            data_q      <= data_d;
            data_vld_q  <= data_vld_d;
        end
    end

    assign nocut_pkt_ram_rd       = rd_q;
    assign nocut_pkt_ram_rd_addr  = rd_addr_q;
    assign buf_addr_wr            = buf_wr_q;
    assign buf_addr               = buf_addr_q;
    assign pkt_metadata_out       = meta_q;
    assign pkt_metadata_out_valid = meta_vld_q;
    assign pkt_out_data           = data_q;
    assign pkt_out_data_valid     = data_vld_q;

`ifdef PKT_OUT_BUF_ERRCNT_EN
    logic [15:0] err_tail_q, err_drop_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_tail_q <= 16'd0;
            err_drop_q <= 16'd0;
        end else begin
            if (miss_tail && err_tail_q != 16'hFFFF) err_tail_q <= err_tail_q + 16'd1;
            if (pkt_metadata_nocut_valid && q_full && err_drop_q != 16'hFFFF)
                err_drop_q <= err_drop_q + 16'd1;
        end
    end

    assign err_missing_tail_cnt = err_tail_q;
    assign err_meta_drop_cnt    = err_drop_q;
`endif

endmodule

// File: tb/tb_pkt_out_buf.sv
// Randomized bench for pkt_out_buf: a RAM model feeds the DUT and a packet-level model predicts
// metadata, words, read addresses and freed IDs.
module tb_pkt_out_buf;

    localparam int LAT = 2;

    logic         clk, reset;
    logic [339:0] meta_in;
    logic         meta_in_valid;
    logic [10:0]  rd_addr;
    logic         rd;
    logic [138:0] ram_q;
    logic         buf_addr_wr;
    logic [3:0]   buf_addr;
    logic [339:0] meta_out;
    logic         meta_out_valid;
    logic [138:0] data_out;
    logic         data_out_valid;
    logic [7:0]   usedw, usedw_fix, usedw_rnd;
    bit           rand_usedw;
`ifdef PKT_OUT_BUF_ERRCNT_EN
    logic [15:0]  err_tail_cnt, err_drop_cnt;
`endif

    pkt_out_buf #(.RAM_RD_LAT(LAT)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .pkt_metadata_nocut       (meta_in),
        .pkt_metadata_nocut_valid (meta_in_valid),
        .nocut_pkt_ram_rd_addr    (rd_addr),
        .nocut_pkt_ram_rd         (rd),
        .nocut_pkt_ram_data_q     (ram_q),
        .buf_addr_wr              (buf_addr_wr),
        .buf_addr                 (buf_addr),
        .pkt_metadata_out         (meta_out),
        .pkt_metadata_out_valid   (meta_out_valid),
        .pkt_out_data             (data_out),
        .pkt_out_data_valid       (data_out_valid),
        .pkt_out_data_usedw       (usedw)
`ifdef PKT_OUT_BUF_ERRCNT_EN
        ,
        .err_missing_tail_cnt     (err_tail_cnt),
        .err_meta_drop_cnt        (err_drop_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: data for an address presented with rd is valid LAT cycles later
    logic [138:0] ram [2048];
    logic [10:0]  rpipe [LAT];
    always @(posedge clk) begin
        rpipe[0] <= rd_addr;
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign ram_q = ram[rpipe[LAT-1]];

    always @(negedge clk) usedw_rnd <= 8'($urandom_range(0, 255));
    assign usedw = rand_usedw ? usedw_rnd : usedw_fix;

    logic [10:0]  rd_obs[$];
    logic [339:0] meta_obs[$];
    logic [138:0] data_obs[$];
    logic [3:0]   free_obs[$];

    always @(negedge clk) begin
        if (reset) begin
            if (rd)             rd_obs.push_back(rd_addr);
            if (meta_out_valid) meta_obs.push_back(meta_out);
            if (data_out_valid) data_obs.push_back(data_out);
            if (buf_addr_wr)    free_obs.push_back(buf_addr);
        end
    end

    typedef struct {
        logic [3:0] id;
        int         len;
    } pkt_t;

    pkt_t         batch[$];
    logic [339:0] exp_meta[$];
    logic [138:0] exp_data[$];
    logic [3:0]   exp_free[$];
    int           exp_err = 0;
    int           n_checks = 0;
    int           n_pass = 0;

    task automatic chk(input string tag, input logic [339:0] obs, input logic [339:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [335:0] rand_meta();
        logic [335:0] m;
        for (int i = 0; i < 10; i++) m[i*32 +: 32] = $urandom;
        m[335:320] = 16'($urandom);
        return m;
    endfunction

    // Fill buffer `id` and record what the packet must look like downstream.
    task automatic prep(input logic [3:0] id, input int len, input bit has_tail, input logic [335:0] meta);
        pkt_t         p;
        logic [138:0] w;
        for (int i = 0; i < 128; i++) begin
            w[135:0]   = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
            w[138:136] = (i == 0) ? 3'b101 : 3'b100;
            if (has_tail && i == len - 1) w[138:136] = 3'b110;
            ram[{id, 7'(i)}] = w;
        end
        p.id  = id;
        p.len = has_tail ? len : 128;
        batch.push_back(p);
        exp_meta.push_back({4'b0, meta});
        for (int i = 0; i < p.len; i++) begin
            w = ram[{id, 7'(i)}];
            if (!has_tail && i == 127) w[138:136] = 3'b110;
            exp_data.push_back(w);
        end
        exp_free.push_back(id);
        if (!has_tail) exp_err++;
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] id, input logic [335:0] meta);
        meta_in       = {id, meta};
        meta_in_valid = 1'b1;
        @(posedge clk);
        #1;
        meta_in_valid = 1'b0;
    endtask

    task automatic clear_all();
        rd_obs.delete(); meta_obs.delete(); data_obs.delete(); free_obs.delete();
        batch.delete(); exp_meta.delete(); exp_data.delete(); exp_free.delete();
    endtask

    task automatic wait_done(input int n, input int budget);
        int k;
        k = 0;
        while (free_obs.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_in_time", 340'(free_obs.size() >= n), 340'(1));
        repeat (10) @(negedge clk);
    endtask

    task automatic check_batch();
        int n, allow, got;
        chk("meta_count", 340'(meta_obs.size()), 340'(exp_meta.size()));
        while (meta_obs.size() > 0 && exp_meta.size() > 0)
            chk("meta", meta_obs.pop_front(), exp_meta.pop_front());
        chk("word_count", 340'(data_obs.size()), 340'(exp_data.size()));
        while (data_obs.size() > 0 && exp_data.size() > 0)
            chk("word", 340'(data_obs.pop_front()), 340'(exp_data.pop_front()));
        chk("free_count", 340'(free_obs.size()), 340'(exp_free.size()));
        while (free_obs.size() > 0 && exp_free.size() > 0)
            chk("free_id", 340'(free_obs.pop_front()), 340'(exp_free.pop_front()));
        foreach (batch[p]) begin
            n     = batch[p].len;
            allow = (128 - n < LAT) ? 128 - n : LAT;
            got   = 0;
            while (rd_obs.size() > 0 && rd_obs[0][10:7] == batch[p].id) begin
                chk("rd_addr", 340'(rd_obs.pop_front()), 340'({batch[p].id, 7'(got)}));
                got++;
            end
            chk("rd_count_in_range", 340'(got >= n && got <= n + allow), 340'(1));
        end
        chk("rd_leftover", 340'(rd_obs.size()), 340'(0));
        clear_all();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rd"},      340'(rd),             340'(0));
        chk({tag, "_addr"},    340'(rd_addr),        340'(0));
        chk({tag, "_wr"},      340'(buf_addr_wr),    340'(0));
        chk({tag, "_bufaddr"}, 340'(buf_addr),       340'(0));
        chk({tag, "_mvld"},    340'(meta_out_valid), 340'(0));
        chk({tag, "_meta"},    meta_out,             340'(0));
        chk({tag, "_dvld"},    340'(data_out_valid), 340'(0));
        chk({tag, "_data"},    340'(data_out),       340'(0));
    endtask

    task automatic check_init();
        int k;
        k = 0;
        while (!buf_addr_wr && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("init_start", 340'(k < 50), 340'(1));
        for (int i = 0; i < 16; i++) begin
            chk("init_wr", 340'(buf_addr_wr), 340'(1));
            chk("init_id", 340'(buf_addr), 340'(i));
            @(negedge clk);
        end
        chk("init_end", 340'(buf_addr_wr), 340'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0]   ids [16];
        logic [335:0] m;
        int           npk, cnt;
        bit           tl;
        reset = 1'b0; meta_in = '0; meta_in_valid = 1'b0;
        rand_usedw = 1'b0; usedw_fix = 8'd0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b1;
        check_init();
        clear_all();

        // ID 2, three-word packet, with cycle-exact latency checks
        align();
        prep(4'd2, 3, 1'b1, 336'hABC);
        pulse(4'd2, 336'hABC);
        @(negedge clk); chk("lat_meta_c0", 340'(meta_out_valid), 340'(0));
        @(negedge clk); chk("lat_meta_c1", 340'(meta_out_valid), 340'(0));
        @(negedge clk); chk("lat_meta_c2", 340'(meta_out_valid), 340'(1));
        chk("lat_rd_c2", 340'(rd), 340'(0));
        @(negedge clk); chk("lat_rd_c3", 340'(rd), 340'(1));
        chk("lat_addr_c3", 340'(rd_addr), 340'(11'h100));
        wait_done(1, 500);
        check_batch();

        // consumer backpressure holds the read until usedw drops
        usedw_fix = 8'd200;
        align();
        m = rand_meta();
        prep(4'd7, 6, 1'b1, m);
        pulse(4'd7, m);
        cnt = 0;
        while (meta_obs.size() < 1 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        repeat (10) @(negedge clk);
        chk("bp_meta_seen", 340'(meta_obs.size()), 340'(1));
        chk("bp_no_rd", 340'(rd_obs.size()), 340'(0));
        align();
        usedw_fix = 8'd100;
        @(negedge clk); chk("bp_rd_before", 340'(rd), 340'(0));
        @(negedge clk); chk("bp_rd_start", 340'(rd), 340'(1));
        chk("bp_rd_addr", 340'(rd_addr), 340'(11'h380));
        wait_done(1, 500);
        check_batch();
        usedw_fix = 8'd0;

        // ID 5 with no tail: full buffer read, last word forced to tail
        align();
        m = rand_meta();
        prep(4'd5, 128, 1'b0, m);
        pulse(4'd5, m);
        wait_done(1, 1000);
        check_batch();
`ifdef PKT_OUT_BUF_ERRCNT_EN
        chk("err_tail_cnt", 340'(err_tail_cnt), 340'(exp_err));
`endif

        // back-to-back pulses, IDs 0 then 1
        align();
        prep(4'd0, 5, 1'b1, 336'h11);
        prep(4'd1, 4, 1'b1, 336'h22);
        pulse(4'd0, 336'h11);
        pulse(4'd1, 336'h22);
        wait_done(2, 1000);
        check_batch();

        // randomized batches with random consumer fill level
        rand_usedw = 1'b1;
        for (int b = 0; b < 10; b++) begin
            for (int i = 0; i < 16; i++) ids[i] = 4'(i);
            for (int i = 15; i > 0; i--) begin
                int j;
                logic [3:0] t;
                j = $urandom_range(0, i);
                t = ids[i]; ids[i] = ids[j]; ids[j] = t;
            end
            npk = $urandom_range(1, 4);
            align();
            for (int i = 0; i < npk; i++) begin
                m  = rand_meta();
                tl = ($urandom_range(0, 7) != 0);
                prep(ids[i], $urandom_range(2, 20), tl, m);
                pulse(ids[i], m);
                repeat ($urandom_range(0, 3)) align();
            end
            wait_done(npk, 3000);
            check_batch();
        end
        rand_usedw = 1'b0;
`ifdef PKT_OUT_BUF_ERRCNT_EN
        chk("err_tail_cnt_rand", 340'(err_tail_cnt), 340'(exp_err));
`endif

        // reset during the 3rd word of a 10-word packet, with another packet queued
        align();
        prep(4'd3, 10, 1'b1, 336'h33);
        prep(4'd4, 6, 1'b1, 336'h44);
        pulse(4'd3, 336'h33);
        pulse(4'd4, 336'h44);
        cnt = 0;
        for (int k = 0; k < 200 && cnt < 3; k++) begin
            @(negedge clk);
            if (data_out_valid) cnt++;
        end
        chk("rst_reached_word3", 340'(cnt), 340'(3));
        #1 reset = 1'b0;
        #1 check_outputs_zero("midrst");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_all();
        exp_err = 0;
        check_init();
        clear_all();
        repeat (60) @(negedge clk);
        chk("post_rst_meta", 340'(meta_obs.size()), 340'(0));
        chk("post_rst_words", 340'(data_obs.size()), 340'(0));
        chk("post_rst_rd", 340'(rd_obs.size()), 340'(0));
        chk("post_rst_free", 340'(free_obs.size()), 340'(0));
`ifdef PKT_OUT_BUF_ERRCNT_EN
        chk("err_tail_after_rst", 340'(err_tail_cnt), 340'(0));
        // stall in WAIT_S, then overfill the queue: 1 popped + 16 queued + 1 dropped
        usedw_fix = 8'd255;
        align();
        for (int i = 0; i < 18; i++) pulse(4'd0, 336'(i));
        repeat (3) @(negedge clk);
        chk("err_drop_cnt", 340'(err_drop_cnt), 340'(1));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
